// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO.
//   clog2      : constant ceiling-log2 used to size RAM addresses.
//   ptr_width  : pointer width (one extra bit so full and empty can be told apart).
//   fwft_state_t : output prefetch FSM states used in first-word-fall-through mode.
package sync_fifo_pkg;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res = res + 1;
      v = v >>> 1;
    end
    return res;
  endfunction

  function automatic int ptr_width(input int depth_width);
    return depth_width + 1;
  endfunction

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    PREFETCH = 2'd1,
    VALID    = 2'd2
  } fwft_state_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Contents and read register are not reset so the array maps onto block RAM.
//   clk     : clock
//   wr_en   : write strobe, wr_data stored at wr_addr
//   rd_en   : read strobe, rd_data loads mem[rd_addr] on the next edge, else holds
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [clog2(DEPTH)-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        rd_en,
  input  logic [clog2(DEPTH)-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   wr_en, wr_data        : write request/data; ignored while wr_full
//   wr_full, almost_full  : full flag, water_level >= ALMOST_FULL_NUM
//   rd_en                 : read request (FWFT: acknowledge of the head word)
//   rd_data, rd_valid     : read data; strobe (standard) or !rd_empty (FWFT)
//   rd_empty, almost_empty: empty flag, water_level <= ALMOST_EMPTY_NUM
//   water_level           : words held, including the FWFT output word
//   overflow, underflow   : sticky error flags, cleared by clr_err
//   peak_level            : max water_level since reset/clr_err
//                           (only with SYNC_FIFO_PEAK_LEVEL_EN defined)
module sync_fifo_fwft
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH_WIDTH      = 10,
  parameter int DATA_WIDTH       = 8,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  output logic                   rd_empty,
  output logic                   almost_empty,
  output logic [DEPTH_WIDTH:0]   water_level,
  output logic                   overflow,
  output logic                   underflow,
`ifdef SYNC_FIFO_PEAK_LEVEL_EN
  output logic [DEPTH_WIDTH:0]   peak_level,
`endif
  input  logic                   clr_err
);

  localparam int PW    = ptr_width(DEPTH_WIDTH);
  localparam int DEPTH = 1 << DEPTH_WIDTH;

  typedef logic [PW-1:0] ptr_t;

  ptr_t                  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, level_n;
  fwft_state_t           state, state_n;
  logic                  wr_acc, ram_re, rd_inc, ram_nonempty;
  logic                  full_n, empty_n;
  logic                  rd_seen, rd_valid_q;
  logic [DATA_WIDTH-1:0] ram_q;

  sync_fifo_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[PW-2:0]),
    .wr_data (wr_data),
    .rd_en   (ram_re),
    .rd_addr (rd_ptr[PW-2:0]),
    .rd_data (ram_q)
  );

  // In FWFT mode the RAM read register doubles as the output register.
  // The head word is read at rd_ptr without advancing it (EMPTY), and rd_ptr
  // only advances once that word is presented (PREFETCH -> VALID), so
  // water_level never dips while a word is in flight.  In VALID an
  // acknowledge reads the next word and advances in the same edge: no bubble.
  always_comb begin
    wr_acc       = wr_en && !wr_full;
    ram_nonempty = (wr_ptr != rd_ptr);
    ram_re       = 1'b0;
    rd_inc       = 1'b0;
    state_n      = state;
    if (FWFT != 0) begin
      unique case (state)
        EMPTY: begin
          if (ram_nonempty) begin
            ram_re  = 1'b1;
            state_n = PREFETCH;
          end
        end
        PREFETCH: begin
          rd_inc  = 1'b1;
          state_n = VALID;
        end
        VALID: begin
          if (rd_en) begin
            if (ram_nonempty) begin
              ram_re = 1'b1;
              rd_inc = 1'b1;
            end else begin
              state_n = EMPTY;
            end
          end
        end
        default: state_n = EMPTY;
      endcase
    end else begin
      ram_re  = rd_en && !rd_empty;
      rd_inc  = ram_re;
      state_n = EMPTY;
    end

    wr_ptr_n = wr_ptr + ptr_t'(wr_acc);
    rd_ptr_n = rd_ptr + ptr_t'(rd_inc);
    level_n  = (wr_ptr_n - rd_ptr_n) + ptr_t'(state_n == VALID);
    full_n   = (wr_ptr_n[PW-1] != rd_ptr_n[PW-1]) &&
               (wr_ptr_n[PW-2:0] == rd_ptr_n[PW-2:0]);
    empty_n  = (FWFT != 0) ? (state_n != VALID) : (wr_ptr_n == rd_ptr_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wr_full      <= 1'b0;
      almost_full  <= 1'b0;
      rd_empty     <= 1'b1;
      almost_empty <= (ALMOST_EMPTY_NUM >= 0);
      water_level  <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_seen      <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      wr_full      <= full_n;
      rd_empty     <= empty_n;
      water_level  <= level_n;
      almost_full  <= (int'(level_n) >= ALMOST_FULL_NUM);
      almost_empty <= (int'(level_n) <= ALMOST_EMPTY_NUM);
      rd_seen      <= rd_seen | ram_re;
      rd_valid_q   <= (FWFT == 0) && ram_re;
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_en && wr_full) overflow <= 1'b1;
        if (rd_en && rd_empty) underflow <= 1'b1;
      end
    end
  end

  // The RAM read register has no reset; mask it until the first read so
  // rd_data reads zero out of reset.
  assign rd_data  = rd_seen ? ram_q : '0;
  assign rd_valid = (FWFT != 0) ? !rd_empty : rd_valid_q;

`ifdef SYNC_FIFO_PEAK_LEVEL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_level <= '0;
    end else if (clr_err) begin
      peak_level <= water_level;
    end else if (level_n > peak_level) begin
      peak_level <= level_n;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
module tb_sync_fifo_fwft;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        s_wr_en, s_rd_en, s_clr;
  logic [7:0]  s_wr_data, s_rd_data;
  logic        s_wr_full, s_af, s_rd_valid, s_rd_empty, s_ae, s_ovf, s_udf;
  logic [10:0] s_lvl;

  logic        f_wr_en, f_rd_en, f_clr;
  logic [7:0]  f_wr_data, f_rd_data;
  logic        f_wr_full, f_af, f_rd_valid, f_rd_empty, f_ae, f_ovf, f_udf;
  logic [4:0]  f_lvl;

`ifdef SYNC_FIFO_PEAK_LEVEL_EN
  logic [10:0] s_peak;
  logic [4:0]  f_peak;
`endif

  sync_fifo_fwft #(
    .DEPTH_WIDTH(10), .DATA_WIDTH(8), .FWFT(0),
    .ALMOST_FULL_NUM(1020), .ALMOST_EMPTY_NUM(4)
  ) dut_std (
    .clk(clk), .rst_n(rst_n),
    .wr_en(s_wr_en), .wr_data(s_wr_data), .wr_full(s_wr_full), .almost_full(s_af),
    .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .rd_empty(s_rd_empty),
    .almost_empty(s_ae), .water_level(s_lvl), .overflow(s_ovf), .underflow(s_udf),
`ifdef SYNC_FIFO_PEAK_LEVEL_EN
    .peak_level(s_peak),
`endif
    .clr_err(s_clr)
  );

  sync_fifo_fwft #(
    .DEPTH_WIDTH(4), .DATA_WIDTH(8), .FWFT(1),
    .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
  ) dut_fwft (
    .clk(clk), .rst_n(rst_n),
    .wr_en(f_wr_en), .wr_data(f_wr_data), .wr_full(f_wr_full), .almost_full(f_af),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .rd_empty(f_rd_empty),
    .almost_empty(f_ae), .water_level(f_lvl), .overflow(f_ovf), .underflow(f_udf),
`ifdef SYNC_FIFO_PEAK_LEVEL_EN
    .peak_level(f_peak),
`endif
    .clr_err(f_clr)
  );

  int checks = 0;
  int passes = 0;
  logic [7:0] s_q[$];
  logic [7:0] f_q[$];
  int s_model = 0;

  // One standard-mode cycle: decides acceptance from the bench's own
  // occupancy count, pushes accepted writes, and at the negedge checks any
  // word delivered by the previous edge's read.
  task automatic s_cycle(input bit we, input logic [7:0] wd, input bit re, input bit clr = 1'b0);
    bit wacc, racc;
    logic [7:0] e;
    s_wr_en = we; s_wr_data = wd; s_rd_en = re; s_clr = clr;
    wacc = we && (s_model < 1024);
    racc = re && (s_model > 0);
    if (wacc) s_q.push_back(wd);
    s_model = s_model + int'(wacc) - int'(racc);
    @(negedge clk);
    if (s_rd_valid) begin
      checks++;
      if (s_q.size() == 0) begin
        $display("FAIL s_scoreboard: rd_valid with no word expected, rd_data=%h", s_rd_data);
      end else begin
        e = s_q.pop_front();
        if (s_rd_data !== e) $display("FAIL s_scoreboard: rd_data=%h expected %h", s_rd_data, e);
        else passes++;
      end
    end
    @(posedge clk); #1;
  endtask

  // One FWFT-mode cycle: rd_data is checked while it is being acknowledged.
  task automatic f_cycle(input bit we, input logic [7:0] wd, input bit re);
    logic [7:0] e;
    f_wr_en = we; f_wr_data = wd; f_rd_en = re; f_clr = 1'b0;
    if (we) f_q.push_back(wd);
    @(negedge clk);
    if (re && !f_rd_empty) begin
      checks++;
      if (f_q.size() == 0) begin
        $display("FAIL f_scoreboard: word acknowledged with none expected, rd_data=%h", f_rd_data);
      end else begin
        e = f_q.pop_front();
        if (f_rd_data !== e) $display("FAIL f_scoreboard: rd_data=%h expected %h", f_rd_data, e);
        else passes++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [6:0] s_flags, f_flags;
    rst_n = 1'b0;
    s_wr_en = 0; s_rd_en = 0; s_clr = 0; s_wr_data = '0;
    f_wr_en = 0; f_rd_en = 0; f_clr = 0; f_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    s_flags = {s_wr_full, s_af, s_rd_empty, s_ae, s_rd_valid, s_ovf, s_udf};
    f_flags = {f_wr_full, f_af, f_rd_empty, f_ae, f_rd_valid, f_ovf, f_udf};
    checks++;
    if (s_flags !== 7'b0011000) $display("FAIL reset_std_flags: got %b expected %b", s_flags, 7'b0011000);
    else passes++;
    checks++;
    if (f_flags !== 7'b0011000) $display("FAIL reset_fwft_flags: got %b expected %b", f_flags, 7'b0011000);
    else passes++;
    checks++;
    if (s_lvl !== 11'd0 || s_rd_data !== 8'h00) $display("FAIL reset_std_level_data: level=%0d data=%h expected 0/00", s_lvl, s_rd_data);
    else passes++;
    checks++;
    if (f_lvl !== 5'd0 || f_rd_data !== 8'h00) $display("FAIL reset_fwft_level_data: level=%0d data=%h expected 0/00", f_lvl, f_rd_data);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_read;
    for (int i = 1; i <= 4; i++) s_cycle(1'b1, 8'(i), 1'b0);
    checks++;
    if (s_lvl !== 11'd4 || s_rd_empty !== 1'b0 || s_ae !== 1'b1)
      $display("FAIL basic_after_writes: level=%0d empty=%b aempty=%b expected 4/0/1", s_lvl, s_rd_empty, s_ae);
    else passes++;
    for (int i = 0; i < 4; i++) s_cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (s_lvl !== 11'd0 || s_rd_empty !== 1'b1)
      $display("FAIL basic_after_reads: level=%0d empty=%b expected 0/1", s_lvl, s_rd_empty);
    else passes++;
    s_cycle(1'b0, 8'h00, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (s_q.size() != 0 || s_rd_data !== 8'h04 || s_rd_valid !== 1'b0)
      $display("FAIL basic_drain: pending=%0d rd_data=%h rd_valid=%b expected 0/04/0", s_q.size(), s_rd_data, s_rd_valid);
    else passes++;
  endtask

  task automatic test_fill_overflow;
    for (int i = 0; i < 1024; i++) begin
      s_cycle(1'b1, 8'(i), 1'b0);
      checks++;
      if (s_lvl !== 11'(i + 1) || s_af !== (i + 1 >= 1020) || s_wr_full !== (i + 1 == 1024) || s_ae !== (i + 1 <= 4))
        $display("FAIL fill_level: write %0d level=%0d af=%b full=%b ae=%b expected level %0d",
                 i + 1, s_lvl, s_af, s_wr_full, s_ae, i + 1);
      else passes++;
    end
    s_cycle(1'b1, 8'hEE, 1'b0);
    checks++;
    if (s_ovf !== 1'b1 || s_lvl !== 11'd1024 || s_wr_full !== 1'b1)
      $display("FAIL overflow_set: ovf=%b level=%0d full=%b expected 1/1024/1", s_ovf, s_lvl, s_wr_full);
    else passes++;
    s_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (s_ovf !== 1'b0) $display("FAIL overflow_clear: ovf=%b expected 0", s_ovf);
    else passes++;
    s_cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    checks++;
    if (s_ovf !== 1'b0) $display("FAIL overflow_clr_priority: ovf=%b expected 0", s_ovf);
    else passes++;
    s_cycle(1'b1, 8'hDD, 1'b1);
    checks++;
    if (s_ovf !== 1'b1 || s_lvl !== 11'd1023 || s_wr_full !== 1'b0 || s_af !== 1'b1)
      $display("FAIL full_read_write: ovf=%b level=%0d full=%b af=%b expected 1/1023/0/1", s_ovf, s_lvl, s_wr_full, s_af);
    else passes++;
    s_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    while (s_model > 0) s_cycle(1'b0, 8'h00, 1'b1);
    s_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (s_q.size() != 0 || s_lvl !== 11'd0 || s_rd_empty !== 1'b1 || s_ovf !== 1'b0)
      $display("FAIL fill_drain: pending=%0d level=%0d empty=%b ovf=%b expected 0/0/1/0", s_q.size(), s_lvl, s_rd_empty, s_ovf);
    else passes++;
  endtask

  task automatic test_underflow;
    s_cycle(1'b1, 8'hAA, 1'b1);
    checks++;
    if (s_udf !== 1'b1 || s_lvl !== 11'd1 || s_rd_empty !== 1'b0)
      $display("FAIL underflow_set: udf=%b level=%0d empty=%b expected 1/1/0", s_udf, s_lvl, s_rd_empty);
    else passes++;
    s_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (s_rd_data !== 8'hFF || s_udf !== 1'b1)
      $display("FAIL underflow_hold: rd_data=%h udf=%b expected ff/1", s_rd_data, s_udf);
    else passes++;
    s_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (s_udf !== 1'b0) $display("FAIL underflow_clear: udf=%b expected 0", s_udf);
    else passes++;
    s_cycle(1'b0, 8'h00, 1'b1);
    s_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (s_q.size() != 0 || s_rd_data !== 8'hAA)
      $display("FAIL underflow_write_lands: pending=%0d rd_data=%h expected 0/aa", s_q.size(), s_rd_data);
    else passes++;
  endtask

  task automatic test_fwft;
    f_cycle(1'b1, 8'h5A, 1'b0);
    checks++;
    if (f_rd_empty !== 1'b1 || f_lvl !== 5'd1)
      $display("FAIL fwft_lat1: empty=%b level=%0d expected 1/1", f_rd_empty, f_lvl);
    else passes++;
    f_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (f_rd_empty !== 1'b1 || f_lvl !== 5'd1)
      $display("FAIL fwft_lat2: empty=%b level=%0d expected 1/1", f_rd_empty, f_lvl);
    else passes++;
    f_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (f_rd_empty !== 1'b0 || f_rd_valid !== 1'b1 || f_rd_data !== 8'h5A || f_lvl !== 5'd1)
      $display("FAIL fwft_head: empty=%b valid=%b data=%h level=%0d expected 0/1/5a/1", f_rd_empty, f_rd_valid, f_rd_data, f_lvl);
    else passes++;
    f_cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (f_rd_empty !== 1'b1 || f_lvl !== 5'd0 || f_q.size() != 0)
      $display("FAIL fwft_consume: empty=%b level=%0d pending=%0d expected 1/0/0", f_rd_empty, f_lvl, f_q.size());
    else passes++;
    for (int i = 0; i < 6; i++) f_cycle(1'b1, 8'(8'h30 + i), 1'b0);
    f_cycle(1'b0, 8'h00, 1'b0);
    f_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (f_lvl !== 5'd6 || f_ae !== 1'b0) $display("FAIL fwft_level6: level=%0d ae=%b expected 6/0", f_lvl, f_ae);
    else passes++;
    for (int i = 0; i < 6; i++) f_cycle(1'b0, 8'h00, 1'b1);
    f_rd_en = 1'b0;
    checks++;
    if (f_q.size() != 0 || f_lvl !== 5'd0 || f_rd_empty !== 1'b1 || f_udf !== 1'b0)
      $display("FAIL fwft_no_bubble: pending=%0d level=%0d empty=%b udf=%b expected 0/0/1/0", f_q.size(), f_lvl, f_rd_empty, f_udf);
    else passes++;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 512; i++) s_cycle(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 3000; i++) begin
      s_cycle(1'b1, 8'($urandom), 1'b1);
      checks++;
      if (s_lvl !== 11'd512) $display("FAIL b2b_level: cycle %0d level=%0d expected 512", i, s_lvl);
      else passes++;
    end
    while (s_model > 0) s_cycle(1'b0, 8'h00, 1'b1);
    s_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (s_q.size() != 0 || s_lvl !== 11'd0 || s_udf !== 1'b0 || s_ovf !== 1'b0)
      $display("FAIL b2b_drain: pending=%0d level=%0d udf=%b ovf=%b expected 0/0/0/0", s_q.size(), s_lvl, s_udf, s_ovf);
    else passes++;
  endtask

  task automatic test_reset_mid;
    logic [6:0] s_flags;
    for (int i = 0; i < 700; i++) s_cycle(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) f_cycle(1'b1, 8'(i), 1'b0);
    s_wr_en = 1'b1; s_rd_en = 1'b1; s_wr_data = 8'h77;
    #2;
    rst_n = 1'b0;
    #1;
    s_flags = {s_wr_full, s_af, s_rd_empty, s_ae, s_rd_valid, s_ovf, s_udf};
    checks++;
    if (s_flags !== 7'b0011000 || s_lvl !== 11'd0 || s_rd_data !== 8'h00)
      $display("FAIL reset_mid_std: flags=%b level=%0d data=%h expected 0011000/0/00", s_flags, s_lvl, s_rd_data);
    else passes++;
    checks++;
    if (f_rd_empty !== 1'b1 || f_lvl !== 5'd0 || f_rd_data !== 8'h00)
      $display("FAIL reset_mid_fwft: empty=%b level=%0d data=%h expected 1/0/00", f_rd_empty, f_lvl, f_rd_data);
    else passes++;
    s_q.delete(); f_q.delete(); s_model = 0;
    s_wr_en = 0; s_rd_en = 0; f_wr_en = 0; f_rd_en = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_rd_empty !== 1'b1 || s_lvl !== 11'd0) $display("FAIL reset_release: empty=%b level=%0d expected 1/0", s_rd_empty, s_lvl);
    else passes++;
`ifdef SYNC_FIFO_PEAK_LEVEL_EN
    checks++;
    if (s_peak !== 11'd0) $display("FAIL reset_peak: peak=%0d expected 0", s_peak);
    else passes++;
`endif
    s_cycle(1'b1, 8'h33, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b1);
    s_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (s_q.size() != 0 || s_rd_data !== 8'h33) $display("FAIL reset_reuse: pending=%0d data=%h expected 0/33", s_q.size(), s_rd_data);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_fill_overflow();
    test_underflow();
    test_fwft();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
